// File: rtl/alu_issue_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_issue_pkg : opcodes, instruction field positions, issue bundle type    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_issue_pkg;

    localparam logic [3:0] OP_NOP         = 4'd0;
    localparam logic [3:0] OP_ADD         = 4'd1;
    localparam logic [3:0] OP_SUB         = 4'd2;
    localparam logic [3:0] OP_AND         = 4'd3;
    localparam logic [3:0] OP_OR          = 4'd4;
    localparam logic [3:0] OP_XOR         = 4'd5;
    localparam logic [3:0] OP_NOT         = 4'd6;
    localparam logic [3:0] OP_SLA         = 4'd7;
    localparam logic [3:0] OP_SRA         = 4'd8;
    localparam logic [3:0] OP_SRL         = 4'd9;
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd10;

    localparam int OP_LSB     = 28;
    localparam int RD_LSB     = 24;
    localparam int RS_LSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int SHAMT_LSB  = 11;
    localparam int IMMSEL_BIT = 10;
    localparam int IMM_LSB    = 0;
    localparam int REG_AW     = 4;

    typedef struct packed {
        logic [31:0]       a;
        logic [31:0]       b;
        logic [4:0]        shamt;
        logic [3:0]        funct;
        logic [REG_AW-1:0] rd;
    } issue_bundle_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op < OP_ILLEGAL_MIN;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_regfile.sv
// +----------------------------------------------------------------------------+
// | alu_issue_regfile : 2R/1W register file, R0 hardwired to zero.             |
// | ALU_ISSUE_BYPASS_EN forwards the same-cycle write data to both read ports. |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_issue_regfile #(
    parameter int NREGS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] raddr_a_i,
    output logic [31:0]              rdata_a_o,
    input  logic [$clog2(NREGS)-1:0] raddr_b_i,
    output logic [31:0]              rdata_b_o,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] waddr_i,
    input  logic [31:0]              wdata_i
);
    logic [31:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = mem_q[raddr_a_i];
`ifdef ALU_ISSUE_BYPASS_EN
        if (we_i && waddr_i == raddr_a_i) rdata_a_o = wdata_i;
`endif
        if (raddr_a_i == '0) rdata_a_o = '0;
    end

    always_comb begin
        rdata_b_o = mem_q[raddr_b_i];
`ifdef ALU_ISSUE_BYPASS_EN
        if (we_i && waddr_i == raddr_b_i) rdata_b_o = wdata_i;
`endif
        if (raddr_b_i == '0) rdata_b_o = '0;
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// +----------------------------------------------------------------------------+
// | alu_issue_stage : decode/operand fetch with scoreboard ahead of the ALU.   |
// | ALU_ISSUE_BYPASS_EN lets a writeback release a stall in its own cycle.     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_issue_stage #(
    parameter int NREGS = 16,
    parameter int IMM_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [31:0]              wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              a,
    output logic [31:0]              b,
    output logic [4:0]               shamt,
    output logic [3:0]               funct,
    output logic [$clog2(NREGS)-1:0] out_rd,
    output logic                     illegal
);
    import alu_issue_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [3:0]       op;
    logic [AW-1:0]    rd, rs, rt;
    logic [4:0]       shamt_f;
    logic             imm_sel;
    logic [IMM_W-1:0] imm;
    logic [31:0]      imm_ext;
    logic [31:0]      rdata_a, rdata_b;

    assign op      = instr[OP_LSB +: 4];
    assign rd      = instr[RD_LSB +: AW];
    assign rs      = instr[RS_LSB +: AW];
    assign rt      = instr[RT_LSB +: AW];
    assign shamt_f = instr[SHAMT_LSB +: 5];
    assign imm_sel = instr[IMMSEL_BIT];
    assign imm     = instr[IMM_LSB +: IMM_W];
    assign imm_ext = {{(32-IMM_W){imm[IMM_W-1]}}, imm};

    alu_issue_regfile #(.NREGS(NREGS)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a_i (rs),
        .rdata_a_o (rdata_a),
        .raddr_b_i (rt),
        .rdata_b_o (rdata_b),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

    logic [NREGS-1:0] pending_q, pending_d, pend_view, wb_clr;
    logic             out_valid_q, illegal_q;
    issue_bundle_t    bundle_q, bundle_d;
    logic             rt_used, hazard, stall, fire, load;

    assign wb_clr = wb_en ? ({{(NREGS-1){1'b0}}, 1'b1} << wb_addr) : '0;

`ifdef ALU_ISSUE_BYPASS_EN
    assign pend_view = pending_q & ~wb_clr;
`else
    assign pend_view = pending_q;
`endif

    // rd is checked too so a later writer never overtakes an in-flight one
    assign rt_used  = (op != OP_NOT) && !imm_sel;
    assign hazard   = pend_view[rs] | (rt_used & pend_view[rt]) | pend_view[rd];
    assign stall    = in_valid & hazard;
    assign in_ready = !stall && (!out_valid_q || out_ready);
    assign fire     = in_valid & in_ready;
    assign load     = fire & (op != OP_NOP) & op_is_legal(op);

    always_comb begin
        pending_d = pending_q & ~wb_clr;
        if (load && rd != '0) pending_d[rd] = 1'b1;
    end

    always_comb begin
        bundle_d.a     = rdata_a;
        bundle_d.b     = imm_sel ? imm_ext : rdata_b;
        bundle_d.shamt = shamt_f;
        bundle_d.funct = op;
        bundle_d.rd    = REG_AW'(rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            bundle_q    <= '0;
        end else begin
            pending_q <= pending_d;
            illegal_q <= fire && !op_is_legal(op);
            if (load) begin
                bundle_q    <= bundle_d;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign a         = bundle_q.a;
    assign b         = bundle_q.b;
    assign shamt     = bundle_q.shamt;
    assign funct     = bundle_q.funct;
    assign out_rd    = bundle_q.rd[AW-1:0];

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU.
- Accepts 32-bit instructions over a valid/ready handshake and reads sources from an internal 16x32 register file.
- Tracks in-flight destinations with a scoreboard and stalls on hazards.
- Presents a registered {a, b, shamt, funct, rd} bundle; ALU results return through the writeback port.

Parameters:
- NREGS, 16, register-file depth; power of two, address width log2(NREGS).
- IMM_W, 10, immediate field width; sign-extended to 32.

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage accepts instruction this cycle
- instr  in  32  instruction word
- wb_en  in  1  writeback strobe
- wb_addr  in  4  writeback register
- wb_data  in  32  writeback value (ALU res)
- out_valid  out  1  bundle valid
- out_ready  in  1  ALU consumes bundle
- a  out  32  operand A
- b  out  32  operand B
- shamt  out  5  shift amount
- funct  out  4  ALU op code
- out_rd  out  4  destination register
- illegal  out  1  one-cycle pulse, illegal opcode dropped

Behaviour:
- Instruction fields:
  - [31:28] op: 0 NOP; 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 SLA, 8 SRA, 9 SRL; 10-15 illegal.
  - [27:24] rd, [23:20] rs, [19:16] rt, [15:11] shamt, [10] imm_sel, [9:0] imm.
- Operands:
  - a = R[rs].
  - b = imm_sel ? sext(imm) : R[rt].
  - NOT ignores rt; rt is not a hazard source for NOT or when imm_sel=1.
- R0 always reads 0; writes to R0 are discarded; rd=0 never sets pending.
- Scoreboard: one pending bit per register.
  - Set on issue of a non-NOP legal op with rd!=0.
  - Cleared by wb_en to wb_addr.
  - Same-cycle set and clear on the same register: set wins.
- Stall condition: in_valid and (pending[rs] or pending[rt-if-used] or pending[rd]).
  - The rd check enforces WAW ordering.
  - The pending check uses the post-clear view defined under Optional Feature.
- in_ready = !stall and (!out_valid or out_ready). Transfer occurs when in_valid and in_ready.
- Output register:
  - Loaded on a legal non-NOP transfer; out_valid set.
  - Cleared when out_ready and no new load.
  - Held stable while out_valid and !out_ready.
- Latency: 1 cycle from accepted instr to out_valid.
- NOP: consumed with in_ready rules, no output, no scoreboard change.
- Illegal opcode:
  - Consumed the same way as NOP, with no output.
  - illegal pulses high the cycle after acceptance.
- Register-file write: on posedge when wb_en and wb_addr!=0, independent of the handshake.
- Reset (async, rst_n=0):
  - out_valid=0, illegal=0, a=b=0, shamt=0, funct=0, out_rd=0.
  - All pending bits cleared; all registers cleared to 0.
  - in_ready may assert on the first edge after deassertion.
- Reset mid-operation drops any held bundle. Writebacks that arrive after reset are still written to the register file; the scoreboard is already clear.

Optional Feature:
- Macro: ALU_ISSUE_BYPASS_EN.
- Defined:
  - A writeback in cycle t clears pending combinationally for the stall check in cycle t.
  - Source reads matching wb_addr (with wb_en) return wb_data, so a dependent instruction issues in the writeback cycle.
- Undefined:
  - Pending clears at the edge only.
  - A dependent instruction stalls through the writeback cycle and issues one cycle later, reading the registered value.

Decomposition:
- Package alu_issue_pkg:
  - Op code constants 0-15, matching the ALU funct encoding 1-9.
  - Instruction field bit positions.
  - Typedef for the issue bundle {a, b, shamt, funct, rd}.
- One sub-module: alu_issue_regfile (2 read ports, 1 write port, R0 hardwired zero, optional bypass).
- Scoreboard and handshake logic stay in the top module.

Test Plan:
- Reset, then wb R3=0x00000005 and R4=0x00000003; issue ADD rd=5 rs=3 rt=4 -> next cycle out_valid=1, a=5, b=3, funct=1, out_rd=5.
- imm_sel=1, imm=0x3FF, op SUB rs=3 -> b=0xFFFFFFFF, funct=2.
- Issue ADD rd=5, then immediately OR rs=5 with out_ready=1:
  - in_ready=0 until wb_en addr=5 data=8.
  - With the bypass macro, issues in the wb cycle with a=8; without it, issues one cycle later with a=8.
- Hold out_ready=0 with a bundle valid -> in_ready=0; a, b, funct stable for 3 cycles; transfer completes when out_ready=1.
- op=12 -> no out_valid, illegal pulses exactly 1 cycle; op=0 -> consumed, nothing output, no pulse.
- Assert rst_n=0 while out_valid=1 and R5 pending -> out_valid=0 immediately; after release, an instruction reading R5 issues with no stall and a=0.
